// File: rtl/mem16x32_arbiter.sv
// Two-requester arbiter/sequencer for the 16x32 memory. Writes respond 2 cycles after accept, reads 3.
// Backpressure: req*_ready is high only in IDLE for the granted requester. Optional macro MEM_ARB_FIXED_PRIORITY_EN.
module mem16x32_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out,
  output logic                  mem_err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPT} state_t;

  state_t                state, state_nxt;
  logic                  last_grant;   // owner of the in-flight transaction as well as the RR pointer
  logic                  gnt_sel;
  logic                  accept;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp0_q, rsp1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  logic                  err_q;
  logic                  done;

  always_comb begin
    gnt_sel = ~req0_valid;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    if (req0_valid && req1_valid) gnt_sel = ~last_grant;
`endif
    accept    = (state == IDLE) && (req0_valid || req1_valid);
    sel_write = gnt_sel ? req1_write : req0_write;
  end

  assign req0_ready = accept && !gnt_sel;
  assign req1_ready = accept &&  gnt_sel;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = sel_write ? WRITE : READ;
      WRITE: state_nxt = IDLE;
      READ:  state_nxt = CAPT;
      CAPT:  state_nxt = IDLE;
    endcase
  end

  assign done = (state == WRITE) || (state == CAPT);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      rsp0_q <= done && !last_grant;
      rsp1_q <= done &&  last_grant;
      if (accept) begin
        last_grant <= gnt_sel;
        addr_q     <= gnt_sel ? req1_addr  : req0_addr;
        wdata_q    <= gnt_sel ? req1_wdata : req0_wdata;
      end
      // Missing Valid_out still completes the transaction so the requester never hangs.
      if (state == CAPT) begin
        if (!mem_valid_out)  err_q    <= 1'b1;
        else if (last_grant) rdata1_q <= mem_data_out;
        else                 rdata0_q <= mem_data_out;
      end
    end
  end

  assign mem_en      = (state == WRITE);
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign rsp0_valid  = rsp0_q;
  assign rsp1_valid  = rsp1_q;
  assign rsp0_rdata  = rdata0_q;
  assign rsp1_rdata  = rdata1_q;
  assign mem_err     = err_q;

endmodule

// File: tb/tb_mem16x32_arbiter.sv
// Directed bench for mem16x32_arbiter with a behavioural 16x32 memory attached.
// Inputs change and outputs are checked on the falling edge of CLK_tb.
module tb_mem16x32_arbiter;

  logic        CLK_tb = 1'b0;
  logic        RST_n;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_data_in, mem_data_out;
  logic [3:0]  mem_address;
  logic        mem_en, mem_valid_out, mem_err;

  logic [31:0] mem_arr [16];
  logic        kill_vld;

  int n_chk = 0, n_err = 0;
  int n_rsp0 = 0, n_rsp1 = 0, n_both = 0;

  always #5 CLK_tb = ~CLK_tb;

  mem16x32_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .CLK(CLK_tb), .RST_n(RST_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_data_in(mem_data_in), .mem_address(mem_address), .mem_en(mem_en),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out), .mem_err(mem_err)
  );

  // Memory: EN=1 writes; EN=0 registers Data_out with Valid_out (suppressible).
  always_ff @(posedge CLK_tb or negedge RST_n) begin
    if (!RST_n) begin
      mem_data_out  <= '0;
      mem_valid_out <= 1'b0;
    end else if (mem_en) begin
      mem_arr[mem_address] <= mem_data_in;
      mem_valid_out        <= 1'b0;
    end else begin
      mem_data_out  <= mem_arr[mem_address];
      mem_valid_out <= !kill_vld;
    end
  end

  always begin
    @(negedge CLK_tb);
    #2;
    if (rsp0_valid) n_rsp0++;
    if (rsp1_valid) n_rsp1++;
    if (req0_ready && req1_ready) n_both++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit p, input bit v, input bit wr, input logic [3:0] a, input logic [31:0] d);
    if (!p) begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_rsp1", rsp1_valid, 0);
    chk("rst_rdata0", rsp0_rdata, 0);
    chk("rst_rdata1", rsp1_rdata, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_data_in, 0);
    chk("rst_err", mem_err, 0);
  endtask

  // Call on a falling edge; returns on the falling edge where the response is visible.
  task automatic issue(input bit p, input bit wr, input logic [3:0] a, input logic [31:0] d,
                       output int lat, output logic en_c1, output logic [3:0] addr_c1);
    int w;
    w = 0;
    drive(p, 1'b1, wr, a, d);
    #1;
    while (!(p ? req1_ready : req0_ready) && w < 20) begin
      @(negedge CLK_tb);
      #1;
      w++;
    end
    chk("accept_seen", 32'(w < 20), 1);
    @(negedge CLK_tb);
    en_c1   = mem_en;
    addr_c1 = mem_address;
    chk("busy_ready", p ? req1_ready : req0_ready, 0);
    drive(p, 1'b0, wr, a, d);
    lat = 1;
    while (!(p ? rsp1_valid : rsp0_valid) && lat < 10) begin
      @(negedge CLK_tb);
      lat++;
    end
  endtask

  initial begin
    int lat, g, c0, c1, base0, gp, exp_gp;
    logic en1;
    logic [3:0] ad1;

    kill_vld = 1'b0;
    RST_n    = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(negedge CLK_tb);
    chk_reset_outputs();
    RST_n = 1'b1;
    @(negedge CLK_tb);

    // Single requester write then read
    issue(0, 1, 4'd5, 32'hDEADBEEF, lat, en1, ad1);
    chk("wr_lat", lat, 2);
    chk("wr_en", en1, 1);
    chk("wr_addr", ad1, 5);
    issue(0, 0, 4'd5, 32'h0, lat, en1, ad1);
    chk("rd_lat", lat, 3);
    chk("rd_en", en1, 0);
    chk("rd_data", rsp0_rdata, 32'hDEADBEEF);

    // Write immediately followed by read of the same word
    issue(0, 1, 4'd7, 32'h12345678, lat, en1, ad1);
    issue(0, 0, 4'd7, 32'h0, lat, en1, ad1);
    chk("wr_rd_lat", lat, 3);
    chk("wr_rd_data", rsp0_rdata, 32'h12345678);

    // Contention: preload words 1 and 2, reset, then both requesters read continuously
    issue(0, 1, 4'd1, 32'hA1A1A1A1, lat, en1, ad1);
    issue(0, 1, 4'd2, 32'hB2B2B2B2, lat, en1, ad1);
    @(negedge CLK_tb);
    RST_n = 1'b0;
    @(negedge CLK_tb);
    RST_n = 1'b1;
    @(negedge CLK_tb);
    drive(0, 1, 0, 4'd1, 0);
    drive(1, 1, 0, 4'd2, 0);
    g = 0; c0 = 0; c1 = 0;
    for (int i = 0; i <= 30; i++) begin
      if (i == 30) begin
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
      end
      #1;
      if (req0_ready || req1_ready) begin
        gp = req1_ready ? 1 : 0;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        exp_gp = 0;
`else
        exp_gp = g % 2;
`endif
        chk("cont_grant", gp, exp_gp);
        g++;
      end
      if (rsp0_valid) begin chk("cont_rdata0", rsp0_rdata, 32'hA1A1A1A1); c0++; end
      if (rsp1_valid) begin chk("cont_rdata1", rsp1_rdata, 32'hB2B2B2B2); c1++; end
      @(negedge CLK_tb);
    end
    chk("cont_grants", g, 10);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    chk("cont_rsp0_cnt", c0, 10);
    chk("cont_rsp1_cnt", c1, 0);
`else
    chk("cont_rsp0_cnt", c0, 5);
    chk("cont_rsp1_cnt", c1, 5);
`endif

    // Address sweep on requester 1
    base0 = n_rsp0;
    for (int a = 0; a < 16; a++) begin
      issue(1, 1, 4'(a), 32'(a + 'h100), lat, en1, ad1);
      chk("sweep_wr_lat", lat, 2);
      chk("sweep_wr_addr", ad1, a);
    end
    for (int a = 0; a < 16; a++) begin
      issue(1, 0, 4'(a), 32'h0, lat, en1, ad1);
      chk("sweep_rd_lat", lat, 3);
      chk("sweep_rd_data", rsp1_rdata, 32'(a + 'h100));
    end
    chk("sweep_no_rsp0", n_rsp0 - base0, 0);
    chk("sweep_err", mem_err, 0);

    // Memory fails to assert Valid_out
    kill_vld = 1'b1;
    issue(1, 0, 4'd3, 32'h0, lat, en1, ad1);
    kill_vld = 1'b0;
    chk("perr_lat", lat, 3);
    chk("perr_rdata_held", rsp1_rdata, 32'h0000010F);
    chk("perr_err", mem_err, 1);
    issue(1, 0, 4'd4, 32'h0, lat, en1, ad1);
    chk("perr_next_data", rsp1_rdata, 32'h00000104);
    chk("perr_sticky", mem_err, 1);

    // Reset in the middle of a read
    @(negedge CLK_tb);
    drive(0, 1, 0, 4'd4, 0);
    #1;
    chk("mid_accept", req0_ready, 1);
    @(negedge CLK_tb);
    drive(0, 0, 0, 0, 0);
    base0 = n_rsp0;
    RST_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (3) @(negedge CLK_tb);
    chk("mid_no_rsp", n_rsp0 - base0, 0);
    RST_n = 1'b1;
    @(negedge CLK_tb);
    issue(0, 0, 4'd4, 32'h0, lat, en1, ad1);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", rsp0_rdata, 32'h00000104);

    @(negedge CLK_tb);
    chk("never_both_ready", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
